// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_slave
// Purpose  : APB4 completer exposing NUM_REGS read/write registers with
//            byte-lane write strobes, WAIT_STATES extra access cycles before
//            PREADY, and PSLVERR on misaligned or out-of-range addresses.
// Ports    : PCLK/PRESETn     - clock (rising edge), async active-low reset
//            PADDR            - byte address
//            PSEL/PENABLE     - APB select / access phase
//            PWRITE/PWDATA    - direction and write data
//            PSTRB            - write byte strobes
//            PRDATA           - read data (non-zero only on good read completion)
//            PREADY/PSLVERR   - completion and error (error valid with PREADY)
// Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int BO   = $clog2(NB);
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so NUM_REGS itself is representable in the range compare.
    localparam int CMPW = ADDR_WIDTH + 1;
    localparam logic [3:0] c_WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_setup;
    logic                    w_done;
    logic                    w_dec;

    logic [3:0]              r_cnt;
    logic [IDXW-1:0]         r_idx;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_strb;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   w_shift;
    logic                    w_misalign;
    logic                    w_range_err;
    logic                    w_err;

    // ------------------------------------------------------------------
    // Address decode (evaluated on the setup cycle only)
    // ------------------------------------------------------------------
    assign w_shift     = PADDR >> BO;
    assign w_range_err = (CMPW'(w_shift) >= CMPW'(NUM_REGS));
    assign w_err       = w_misalign | w_range_err;

    generate
        if (BO > 0) begin : g_align_chk
            assign w_misalign = |PADDR[BO-1:0];
        end else begin : g_no_align_chk
            assign w_misalign = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_setup = 1'b0;
        w_done  = 1'b0;
        w_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // PSEL with PENABLE already high lacks a setup phase: ignored.
                if (PSEL && !PENABLE) begin
                    w_setup = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    w_next = S_IDLE;            // abort, nothing committed
                end else if (r_cnt == 4'd0) begin
                    w_done = 1'b1;
                    // A back-to-back setup is seen from IDLE on the next cycle.
                    w_next = S_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer capture and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
        end else if (w_setup) begin
            r_cnt   <= c_WAIT_CNT;
            r_idx   <= w_shift[IDXW-1:0];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
            r_err   <= w_err;
        end else if (w_dec) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Register bank: commit at the edge closing the completion cycle
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_done && r_write && !r_err) begin
            for (int b = 0; b < NB; b++) begin
                if (r_strb[b]) begin
                    r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all qualified by the completion cycle so reset clears them
    // immediately through r_state.
    // ------------------------------------------------------------------
    assign PREADY  = w_done;
    assign PSLVERR = w_done & r_err;
    assign PRDATA  = (w_done && !r_write && !r_err) ? r_regs[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regfile_slave
// Purpose  : Self-checking bench. Instance 0 uses WAIT_STATES=0, instance 1
//            uses WAIT_STATES=3; both use the default 32-bit, 16-register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_slave;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic [7:0]  paddr   [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(0)
    ) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n[0]), .PADDR(paddr[0]), .PSEL(psel[0]),
        .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PSTRB(pstrb[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(3)
    ) u_dut3 (
        .PCLK(clk), .PRESETn(rst_n[1]), .PADDR(paddr[1]), .PSEL(psel[1]),
        .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PSTRB(pstrb[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One complete transfer: setup, then access until PREADY (bounded).
    // Address/data are scrambled during wait states; the DUT must ignore that.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int waits);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        @(negedge clk);
        penable[d] = 1'b1;
        waits = 0;
        #1;
        while (!pready[d] && waits < 40) begin
            paddr[d]  = a ^ 8'h04;
            pwdata[d] = ~wd;
            @(negedge clk);
            #1;
            waits++;
        end
        if (!pready[d]) begin
            chk("xfer_timeout", 64'(pready[d]), 64'd1);
        end
        rd = prdata[d];
        er = pslverr[d];
    endtask

    task automatic bus_idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    vec_t        vecs [13];
    logic [31:0] rd;
    logic        er;
    int          w;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; paddr[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0;
            pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0;
        end

        //           wr    addr   wdata          strb     exp_rd         err
        vecs[0]  = '{1'b1, 8'h10, 32'hA5A5A5A5, 4'hF,    32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'hA5A5A5A5, 1'b0};
        vecs[2]  = '{1'b1, 8'h10, 32'h12345678, 4'b0101, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'hA534A578, 1'b0};
        vecs[4]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'h0,    32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 8'h20, 32'h0,        4'h0,    32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 8'h40, 32'h0,        4'h0,    32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 8'h13, 32'hFFFFFFFF, 4'hF,    32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'hA534A578, 1'b0};
        vecs[9]  = '{1'b1, 8'h3C, 32'hCAFEBEEF, 4'b0011, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 8'h3C, 32'h0,        4'h0,    32'h0000BEEF, 1'b0};
        vecs[11] = '{1'b0, 8'h02, 32'h0,        4'h0,    32'h00000000, 1'b1};
        vecs[12] = '{1'b1, 8'hFC, 32'h11111111, 4'hF,    32'h00000000, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_pready0",  64'(pready[0]),  64'd0);
        chk("reset_pslverr0", 64'(pslverr[0]), 64'd0);
        chk("reset_prdata0",  64'(prdata[0]),  64'd0);
        chk("reset_pready1",  64'(pready[1]),  64'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // ---- Zero-wait table, back-to-back transfers ----
        for (int i = 0; i < 13; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, w);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_err",   i), 64'(er), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_waits", i), 64'(w),  64'd0);
        end
        bus_idle(0);

        // ---- Protocol violation: PENABLE without setup is ignored ----
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 8'h24; pwdata[0] = 32'h55AA55AA; pstrb[0] = 4'hF;
        #1 chk("noset_pready_c1", 64'(pready[0]), 64'd0);
        @(negedge clk);
        #1 chk("noset_pready_c2", 64'(pready[0]), 64'd0);
        bus_idle(0);
        xfer(0, 1'b0, 8'h24, 32'h0, 4'h0, rd, er, w);
        chk("noset_readback", 64'(rd), 64'd0);
        bus_idle(0);

        // ---- WAIT_STATES=3: write then read 0x20 ----
        xfer(1, 1'b1, 8'h20, 32'hDEADBEEF, 4'hF, rd, er, w);
        chk("ws3_wr_waits", 64'(w),  64'd3);
        chk("ws3_wr_err",   64'(er), 64'd0);
        xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, w);
        chk("ws3_rd_waits", 64'(w),  64'd3);
        chk("ws3_rd_data",  64'(rd), 64'hDEADBEEF);
        xfer(1, 1'b0, 8'h44, 32'h0, 4'h0, rd, er, w);
        chk("ws3_err_waits", 64'(w),  64'd3);
        chk("ws3_err_flag",  64'(er), 64'd1);
        chk("ws3_err_data",  64'(rd), 64'd0);
        bus_idle(1);

        // ---- Abort: drop PSEL in 2nd access cycle of write to 0x30 ----
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h30; pwdata[1] = 32'h12121212; pstrb[1] = 4'hF;
        @(negedge clk);
        penable[1] = 1'b1;
        #1 chk("abort_acc1_pready", 64'(pready[1]), 64'd0);
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        #1 chk("abort_acc2_pready", 64'(pready[1]), 64'd0);
        chk("abort_acc2_pslverr", 64'(pslverr[1]), 64'd0);
        xfer(1, 1'b0, 8'h30, 32'h0, 4'h0, rd, er, w);
        chk("abort_readback", 64'(rd), 64'd0);
        chk("abort_next_waits", 64'(w), 64'd3);
        xfer(1, 1'b1, 8'h30, 32'h0F0F0F0F, 4'hF, rd, er, w);
        xfer(1, 1'b0, 8'h30, 32'h0, 4'h0, rd, er, w);
        chk("after_abort_wr_rd", 64'(rd), 64'h0F0F0F0F);
        xfer(1, 1'b1, 8'h10, 32'h5A5A5A5A, 4'hF, rd, er, w);
        bus_idle(1);

        // ---- Reset during a wait state ----
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h10; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1 chk("rst_mid_pready",  64'(pready[1]),  64'd0);
        chk("rst_mid_pslverr", 64'(pslverr[1]), 64'd0);
        chk("rst_mid_prdata",  64'(prdata[1]),  64'd0);
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, w);
        chk("rst_rd_10", 64'(rd), 64'd0);
        xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, w);
        chk("rst_rd_20", 64'(rd), 64'd0);
        bus_idle(1);

        // ---- Async reset during a read completion cycle (zero-wait) ----
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h10;
        @(negedge clk);
        penable[0] = 1'b1;
        #1 chk("pre_rst_prdata", 64'(prdata[0]), 64'hA534A578);
        #1 rst_n[0] = 1'b0;
        #1 chk("async_rst_pready", 64'(pready[0]), 64'd0);
        chk("async_rst_prdata", 64'(prdata[0]), 64'd0);
        @(negedge clk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, w);
        chk("async_rst_rd_10", 64'(rd), 64'd0);
        bus_idle(0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- Parametrised APB4 completer: bank of NUM_REGS read/write registers with byte strobes, programmable wait states and error response.
- Successor to the current fixed apb_slave and drop-in for the same bus fabric.
- Adds three features: PSTRB byte-lane writes, PREADY stretching by WAIT_STATES, and PSLVERR on out-of-range or misaligned access.

Parameters:
- DATA_WIDTH, 32: data bus width; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 8: byte address width; must be at least clog2(NUM_REGS) + clog2(DATA_WIDTH/8).
- NUM_REGS, 16: number of registers, 1 to 256.
- WAIT_STATES, 0: extra access cycles before PREADY, 0 to 15.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn low, takes effect immediately, asynchronous):
  - all registers 0; FSM to IDLE; wait counter 0.
  - PREADY, PSLVERR and PRDATA all 0.
- Register decode:
  - BO = clog2(DATA_WIDTH/8); index = PADDR >> BO.
  - err = (PADDR[BO-1:0] != 0) OR (index >= NUM_REGS). err is computed from the PADDR sampled at setup.
- FSM states: IDLE, ACCESS.
  - IDLE: PSEL=1 and PENABLE=0 is a setup cycle. At that edge, latch PADDR, PWRITE, PWDATA, PSTRB and err; load cnt = WAIT_STATES; go to ACCESS.
  - IDLE: PSEL=1 and PENABLE=1 with no prior setup is a protocol violation. It is ignored: PREADY stays 0 and nothing is written.
  - ACCESS, PSEL=0: abort. Go to IDLE with no write and no error.
  - ACCESS, cnt != 0: PREADY=0; cnt decrements each cycle.
  - ACCESS, cnt == 0: PREADY=1 combinationally. This is the completion cycle.
  - Exit from the completion cycle: go to IDLE, or straight to ACCESS if the next setup cycle follows immediately (back-to-back is allowed; a new setup cycle is required).
- Latency: PREADY is high in access cycle number WAIT_STATES+1 after setup. WAIT_STATES=0 gives zero-wait APB.
- Write commit:
  - Commits at the rising edge ending the completion cycle, only if err=0.
  - Byte lane b of register[index] updates only when PSTRB[b]=1.
  - PSTRB all 0 completes with PSLVERR=0 and no change.
- Read data:
  - PRDATA = register[index] during the completion cycle of a read with err=0.
  - PRDATA = 0 in every other cycle, including errored reads.
- PSLVERR = err during the completion cycle; 0 otherwise. Errored writes leave all registers unchanged.
- Reset mid-transfer: the transfer is dropped and no partial write occurs. The master must restart with a setup cycle.
- PWDATA/PADDR changes during wait states are ignored, because values are latched at setup.

Test Plan:
1. Default params: write 0x10 = 0xA5A5A5A5 with PSTRB=0xF, then read 0x10 -> PREADY in first access cycle, PRDATA=0xA5A5A5A5, PSLVERR=0.
2. Strobes: write 0x10 = 0x12345678 with PSTRB=4'b0101 over 0xA5A5A5A5, read 0x10 -> 0xA534A578; write 0x20 with PSTRB=0 -> 0x20 reads 0.
3. WAIT_STATES=3: write 0x20 = 0xDEADBEEF -> PREADY low for 3 access cycles, high on the 4th; register unchanged until that edge; read-back 0xDEADBEEF with the same 4-cycle access.
4. Errors (NUM_REGS=16): read 0x40 -> PREADY=1, PSLVERR=1, PRDATA=0; write 0x13 = 0xFFFFFFFF (misaligned) -> PSLVERR=1, and 0x10 still reads its prior value.
5. WAIT_STATES=3: drop PSEL in the 2nd access cycle of a write to 0x30 -> no PREADY, 0x30 still reads 0; next back-to-back transfer completes normally.
6. Assert PRESETn low during a wait state -> PREADY=0, PSLVERR=0 and PRDATA=0 immediately; after release, 0x10 and 0x20 read 0.
